// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   uart_rx_state_t : receiver FSM state encoding
//   UART_DATA_BITS  : payload width of one frame
//   clocks_per_bit(): system clocks per bit time (integer division); shared
//                     with the transmitter side
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY    = 3'd3,
`endif
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } uart_rx_state_t;

    function automatic int clocks_per_bit(input int clock_frequency, input int baud_rate);
        return clock_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/synchronizer.sv
// Two-flop synchroniser for a single asynchronous input.
//   clock    : destination clock
//   reset    : asynchronous active-high reset; both flops load RESET_VALUE
//   async_in : asynchronous input
//   sync_out : synchronised output (2-cycle latency)
module synchronizer #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta     <= RESET_VALUE;
            sync_out <= RESET_VALUE;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 8 data bits LSB first, 1 stop bit, optional even parity
// (compile-time macro UART_RX_PARITY_EN). Completed bytes go to a one-byte
// holding register with a valid/ready handshake.
//   clock, reset   : system clock, asynchronous active-high reset
//   uart_receive   : raw RX line, idle high, asynchronous
//   data, valid    : held byte and its valid flag
//   ready          : consumer accepts data when valid && ready
//   framing_error  : 1-cycle pulse, stop bit sampled low
//   parity_error   : 1-cycle pulse, parity mismatch (0 without UART_RX_PARITY_EN)
//   overrun        : 1-cycle pulse, byte dropped because holding register full
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | line idle, waiting for a low level on rx_s
// START      | half-bit wait, then confirm start bit (high = glitch)
// DATA       | sample 8 data bits at bit centres
// PARITY     | sample parity bit and latch mismatch (parity builds only)
// STOP       | sample stop bit, deliver byte or pulse an error
// WAIT_IDLE  | after a framing error, hold until the line returns high
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 100000000,
    parameter int BAUD_RATE       = 115200
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      uart_receive,
    output logic [UART_DATA_BITS-1:0] data,
    output logic                      valid,
    input  logic                      ready,
    output logic                      framing_error,
    output logic                      parity_error,
    output logic                      overrun
);

    localparam int CLOCKS_PER_BIT = clocks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int CNT_W          = $clog2(CLOCKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_IDX  = 3'(UART_DATA_BITS - 1);

    logic                      rx_s;
    uart_rx_state_t            state;
    logic [CNT_W-1:0]          bit_cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shift_reg;
    logic                      cnt_done;
`ifdef UART_RX_PARITY_EN
    logic                      parity_fault;
`else
    assign parity_error = 1'b0;
`endif

    synchronizer #(.RESET_VALUE(1'b1)) u_rx_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (uart_receive),
        .sync_out (rx_s)
    );

    assign cnt_done = (bit_cnt == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            bit_idx       <= '0;
            shift_reg     <= '0;
            data          <= '0;
            valid         <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_fault  <= 1'b0;
            parity_error  <= 1'b0;
`endif
        end else begin
            framing_error <= 1'b0;
            overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error  <= 1'b0;
`endif
            // Consumption; a delivery later in this cycle overrides it.
            if (valid && ready)
                valid <= 1'b0;

            if (state != ST_IDLE && state != ST_WAIT_IDLE && !cnt_done)
                bit_cnt <= bit_cnt - 1'b1;

            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        bit_cnt <= HALF_LOAD;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_done) begin
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end else begin
                            bit_cnt <= FULL_LOAD;
                            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                            parity_fault <= 1'b0;
`endif
                            state   <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (cnt_done) begin
                        shift_reg[bit_idx] <= rx_s;
                        bit_cnt            <= FULL_LOAD;
                        if (bit_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt_done) begin
                        // Even parity: data bits plus parity bit XOR to 0.
                        parity_fault <= (^shift_reg) ^ rx_s;
                        bit_cnt      <= FULL_LOAD;
                        state        <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt_done) begin
                        if (!rx_s) begin
                            framing_error <= 1'b1;
                            state         <= ST_WAIT_IDLE;
                        end else begin
                            state <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
                            if (parity_fault)
                                parity_error <= 1'b1;
                            else
`endif
                            if (!valid || ready) begin
                                data  <= shift_reg;
                                valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rx_s)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

    localparam int BIT = 16;

    logic       clock;
    logic       reset;
    logic       uart_receive;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       framing_error;
    logic       parity_error;
    logic       overrun;

    int passed = 0;
    int total  = 0;

    // Event counters, sampled on the falling edge away from the active edge.
    int         valid_rise = 0;
    int         valid_cyc  = 0;
    int         fe_cyc     = 0;
    int         pe_cyc     = 0;
    int         ov_cyc     = 0;
    logic       valid_prev = 1'b0;
    logic [7:0] last_data  = 8'h00;

    int s_vr, s_vc, s_fe, s_pe, s_ov;

    uart_receiver #(.CLOCK_FREQUENCY(16), .BAUD_RATE(1)) dut (
        .clock         (clock),
        .reset         (reset),
        .uart_receive  (uart_receive),
        .data          (data),
        .valid         (valid),
        .ready         (ready),
        .framing_error (framing_error),
        .parity_error  (parity_error),
        .overrun       (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset) begin
            valid_prev <= 1'b0;
        end else begin
            valid_prev <= valid;
            if (valid) valid_cyc <= valid_cyc + 1;
            if (valid && !valid_prev) begin
                valid_rise <= valid_rise + 1;
                last_data  <= data;
            end
            if (framing_error) fe_cyc <= fe_cyc + 1;
            if (parity_error)  pe_cyc <= pe_cyc + 1;
            if (overrun)       ov_cyc <= ov_cyc + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic snap();
        s_vr = valid_rise; s_vc = valid_cyc; s_fe = fe_cyc; s_pe = pe_cyc; s_ov = ov_cyc;
    endtask

    task automatic send_bit(input logic v, input int n);
        uart_receive = v;
        repeat (n) @(posedge clock);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        send_bit(1'b0, BIT);
        for (int i = 0; i < 8; i++) send_bit(b[i], BIT);
`ifdef UART_RX_PARITY_EN
        send_bit(par, BIT);
`else
        if (par === 1'bx) send_bit(1'b1, 0);
`endif
        send_bit(stop, BIT);
        uart_receive = 1'b1;
    endtask

    task automatic idle(input int n);
        uart_receive = 1'b1;
        repeat (n) @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; uart_receive = 1'b1; ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        idle(4);
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 0);
        check("rst_fe", framing_error, 0);
        check("rst_pe", parity_error, 0);
        check("rst_ov", overrun, 0);

        // Single byte, ready held high: one-cycle valid.
        snap();
        send_frame(8'hA5, ^8'hA5, 1'b1);
        idle(8);
        check("a5_rise", valid_rise - s_vr, 1);
        check("a5_vcyc", valid_cyc - s_vc, 1);
        check("a5_data", last_data, 8'hA5);
        check("a5_fe", fe_cyc - s_fe, 0);
        check("a5_pe", pe_cyc - s_pe, 0);
        check("a5_ov", ov_cyc - s_ov, 0);

        // Back-to-back with ready low: first byte held, second overruns.
        ready = 1'b0;
        snap();
        send_frame(8'h3C, ^8'h3C, 1'b1);
        send_frame(8'hC3, ^8'hC3, 1'b1);
        idle(8);
        check("ov_valid", valid, 1);
        check("ov_data", data, 8'h3C);
        check("ov_rise", valid_rise - s_vr, 1);
        check("ov_count", ov_cyc - s_ov, 1);
        check("ov_fe", fe_cyc - s_fe, 0);
        ready = 1'b1;
        @(posedge clock); #1;
        check("ov_drop", valid, 0);
        check("ov_keep", data, 8'h3C);
        ready = 1'b1;
        idle(4);

        // Short low glitch: rejected, next frame fine.
        snap();
        send_bit(1'b0, 5);
        idle(30);
        check("gl_rise", valid_rise - s_vr, 0);
        check("gl_fe", fe_cyc - s_fe, 0);
        check("gl_pe", pe_cyc - s_pe, 0);
        send_frame(8'h01, ^8'h01, 1'b1);
        idle(8);
        check("gl_rise2", valid_rise - s_vr, 1);
        check("gl_data", last_data, 8'h01);

        // Framing error, break held, then recovery.
        snap();
        send_frame(8'h55, ^8'h55, 1'b0);
        send_bit(1'b0, 40);
        idle(20);
        check("fe_count", fe_cyc - s_fe, 1);
        check("fe_rise", valid_rise - s_vr, 0);
        check("fe_pe", pe_cyc - s_pe, 0);
        check("fe_ov", ov_cyc - s_ov, 0);
        send_frame(8'hFF, ^8'hFF, 1'b1);
        idle(8);
        check("fe_rec_rise", valid_rise - s_vr, 1);
        check("fe_rec_data", last_data, 8'hFF);

`ifdef UART_RX_PARITY_EN
        snap();
        send_frame(8'h07, 1'b1, 1'b1);
        idle(8);
        check("par_ok_data", last_data, 8'h07);
        check("par_ok_pe", pe_cyc - s_pe, 0);
        snap();
        send_frame(8'h07, 1'b0, 1'b1);
        idle(8);
        check("par_bad_pe", pe_cyc - s_pe, 1);
        check("par_bad_rise", valid_rise - s_vr, 0);
`endif

        // Reset mid-frame while a byte is being held.
        ready = 1'b0;
        send_frame(8'h5A, ^8'h5A, 1'b1);
        idle(8);
        check("pre_rst_valid", valid, 1);
        check("pre_rst_data", data, 8'h5A);
        send_bit(1'b0, BIT);
        for (int i = 0; i < 4; i++) send_bit(i[0] ? 1'b0 : 1'b0, BIT);
        send_bit(1'b1, 8);
        @(negedge clock); #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", valid, 0);
        check("mid_rst_data", data, 8'h00);
        check("mid_rst_fe", framing_error, 0);
        uart_receive = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        snap();
        idle(40);
        check("post_rst_rise", valid_rise - s_vr, 0);
        check("post_rst_fe", fe_cyc - s_fe, 0);
        ready = 1'b1;
        send_frame(8'h81, ^8'h81, 1'b1);
        idle(8);
        check("post_rst_rise2", valid_rise - s_vr, 1);
        check("post_rst_data", last_data, 8'h81);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
